// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: command FIFO plus a one-transaction-at-a-time sequencer feeding the SPI master.
// Optional length screening is compiled in with `define SPI_CMD_LEN_CHECK_EN.
module spi_cmd_queue #(
    parameter int data_depth = 24,
    parameter int fifo_depth = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_dir,
    input  logic [7:0]                  cmd_len,
    input  logic [data_depth-1:0]       cmd_data,
    output logic                        cmd_err,
    output logic                        rsp_valid,
    output logic [data_depth-1:0]       rsp_data,
    output logic                        spi_start,
    output logic                        spi_dir,
    output logic [7:0]                  spi_data_depth,
    output logic [data_depth-1:0]       spi_data_tx,
    input  logic                        spi_ready,
    input  logic                        spi_read_finish,
    input  logic [data_depth-1:0]       spi_data_rx,
    output logic [$clog2(fifo_depth):0] level,
    output logic                        busy
);

    // Handshake: a command transfers on every rising clk edge where cmd_valid and cmd_ready are
    // both high; the host holds cmd_dir/cmd_len/cmd_data stable while cmd_valid waits for ready.

    localparam int AW = $clog2(fifo_depth);
    localparam int PW = AW + 1;
    localparam int EW = data_depth + 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]          mem_q [fifo_depth];

    logic                   spi_start_q, spi_start_d;
    logic                   spi_dir_q, spi_dir_d;
    logic [7:0]             spi_len_q, spi_len_d;
    logic [data_depth-1:0]  spi_tx_q, spi_tx_d;

    logic                   rf_q, rf_prev_q;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [data_depth-1:0]  rsp_data_q, rsp_data_d;

    logic                   empty, full;
    logic                   accept, push, pop;
    logic                   len_bad;
    logic                   read_rise;
    logic [EW-1:0]          head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && !len_bad;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SPI_CMD_LEN_CHECK_EN
    localparam logic [7:0] LEN_MAX = 8'(data_depth);

    logic cmd_err_q;

    // Rejected commands still complete the handshake so the host never stalls on them.
    assign len_bad = (cmd_len == 8'd0) || (cmd_len > LEN_MAX);
    assign cmd_err = cmd_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= accept && len_bad;
        end
    end
`else
    assign len_bad = 1'b0;
    assign cmd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_dir, cmd_len, cmd_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        spi_start_d = 1'b0;
        spi_dir_d   = spi_dir_q;
        spi_len_d   = spi_len_q;
        spi_tx_d    = spi_tx_q;
        case (state_q)
            IDLE: begin
                // Waiting for spi_ready also keeps a master still leaving reset from a double start.
                if (!empty && spi_ready) begin
                    pop         = 1'b1;
                    spi_start_d = 1'b1;
                    spi_dir_d   = head[EW-1];
                    spi_len_d   = head[EW-2 -: 8];
                    spi_tx_d    = head[data_depth-1:0];
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!spi_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // Edge is taken from the registered copy, so capture lands one cycle after the master's pulse.
    assign read_rise   = rf_q && !rf_prev_q;
    assign rsp_valid_d = read_rise && (state_q == WAIT_DONE) && spi_dir_q;
    assign rsp_data_d  = rsp_valid_d ? spi_data_rx : rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            spi_start_q <= 1'b0;
            spi_dir_q   <= 1'b0;
            spi_len_q   <= '0;
            spi_tx_q    <= '0;
            rf_q        <= 1'b0;
            rf_prev_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            spi_start_q <= spi_start_d;
            spi_dir_q   <= spi_dir_d;
            spi_len_q   <= spi_len_d;
            spi_tx_q    <= spi_tx_d;
            rf_q        <= spi_read_finish;
            rf_prev_q   <= rf_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign spi_start      = spi_start_q;
    assign spi_dir        = spi_dir_q;
    assign spi_data_depth = spi_len_q;
    assign spi_data_tx    = spi_tx_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign level          = wr_ptr_q - rd_ptr_q;
    assign busy           = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_queue.sv
// tb_spi_cmd_queue: randomized scoreboard bench for spi_cmd_queue with a behavioural SPI master.
// Expectations follow SPI_CMD_LEN_CHECK_EN the same way the design does.
module tb_spi_cmd_queue;

    localparam int DW = 24;
    localparam int FD = 8;
    localparam int EW = DW + 9;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid, cmd_ready, cmd_dir, cmd_err;
    logic [7:0]            cmd_len;
    logic [DW-1:0]         cmd_data;
    logic                  rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  spi_start, spi_dir;
    logic [7:0]            spi_data_depth;
    logic [DW-1:0]         spi_data_tx;
    logic                  spi_ready, spi_read_finish;
    logic [DW-1:0]         spi_data_rx;
    logic [$clog2(FD):0]   level;
    logic                  busy;

    spi_cmd_queue #(.data_depth(DW), .fifo_depth(FD)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_len         (cmd_len),
        .cmd_data        (cmd_data),
        .cmd_err         (cmd_err),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .spi_start       (spi_start),
        .spi_dir         (spi_dir),
        .spi_data_depth  (spi_data_depth),
        .spi_data_tx     (spi_data_tx),
        .spi_ready       (spi_ready),
        .spi_read_finish (spi_read_finish),
        .spi_data_rx     (spi_data_rx),
        .level           (level),
        .busy            (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required finish within budget");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    int n_rsp = 0;

    logic [EW-1:0] exp_q[$];      // commands expected to reach the master, in order
    logic [DW-1:0] rsp_q[$];      // read words the master handed back, awaiting rsp_valid
    int            rsp_cyc_q[$];  // cycle on which each rsp_valid is due

    logic          stall = 1'b0;
    logic [DW-1:0] rx_word;
    int            m_phase = 0;
    int            m_cnt = 0;
    int            m_rf = 0;
    int            m_recover = 0;
    logic [EW-1:0] m_cur = '0;
    logic          ready_before;
    logic          rsp_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic len_bad(input logic [7:0] l);
`ifdef SPI_CMD_LEN_CHECK_EN
        return (l == 8'd0) || (l > 8'(DW));
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- behavioural SPI master + command monitor ----------------
    initial begin
        spi_ready       = 1'b0;
        spi_read_finish = 1'b0;
        spi_data_rx     = '0;
        forever begin
            @(posedge clk);
            #1;
            ready_before = spi_ready;
            if (rst) begin
                m_phase         = 0;
                m_recover       = 3;
                spi_ready       = 1'b0;
                spi_read_finish = 1'b0;
            end else begin
                case (m_phase)
                    0: begin
                        if (m_recover > 0) begin
                            m_recover--;
                            spi_ready = 1'b0;
                        end else begin
                            spi_ready = !stall;
                        end
                        if (spi_start) begin
                            check("start_while_master_busy", 64'(ready_before), 64'd1);
                            n_starts++;
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL unexpected_start: got spi_start=1 tx=0x%0h, required no start", spi_data_tx);
                                m_cur = {spi_dir, spi_data_depth, spi_data_tx};
                            end else begin
                                m_cur = exp_q.pop_front();
                                check("start_fields", 64'({spi_dir, spi_data_depth, spi_data_tx}), 64'(m_cur));
                            end
                            m_cnt   = $urandom_range(2, 5);
                            m_phase = 1;
                        end
                    end
                    1: begin
                        spi_ready = 1'b0;
                        check("start_width", 64'(spi_start), 64'd0);
                        check("fields_stable", 64'({spi_dir, spi_data_depth, spi_data_tx}), 64'(m_cur));
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            m_phase = m_cur[EW-1] ? 2 : 3;
                            m_rf    = 2;
                        end
                    end
                    2: begin
                        spi_ready = 1'b0;
                        if (m_rf == 2) begin
                            spi_data_rx = rx_word;
                            rsp_q.push_back(rx_word);
                            rsp_cyc_q.push_back(cyc + 2);
                            rx_word = DW'($urandom);
                        end
                        spi_read_finish = 1'b1;
                        check("start_width", 64'(spi_start), 64'd0);
                        check("fields_stable", 64'({spi_dir, spi_data_depth, spi_data_tx}), 64'(m_cur));
                        m_rf = m_rf - 1;
                        if (m_rf == 0) m_phase = 3;
                    end
                    default: begin
                        spi_read_finish = 1'b0;
                        spi_ready       = 1'b1;
                        check("fields_stable", 64'({spi_dir, spi_data_depth, spi_data_tx}), 64'(m_cur));
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rsp_valid) begin
                check("rsp_valid_width", 64'(rsp_prev), 64'd0);
                n_rsp++;
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h, required no response", rsp_data);
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(rsp_q.pop_front()));
                    check("rsp_latency", 64'(cyc), 64'(rsp_cyc_q.pop_front()));
                end
            end
            rsp_prev = rsp_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic d, input logic [7:0] l, input logic [DW-1:0] w);
        int t;
        logic bad;
        t = 0;
        bad = len_bad(l);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_len   = l;
        cmd_data  = w;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 200);
        if (!cmd_ready) begin
            check("send_timeout", 64'(cmd_ready), 64'd1);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!bad) exp_q.push_back({d, l, w});
        check("cmd_err", 64'(cmd_err), 64'(bad));
    endtask

    task automatic send_rand();
        logic [7:0] l;
        l = 8'($urandom_range(1, DW));
        send(1'($urandom_range(0, 1)), l, DW'($urandom));
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (t < budget && (busy || m_phase != 0 || exp_q.size() != 0));
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int t;
        logic ok;
        logic [7:0] l;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        rx_word   = DW'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_cmd_err", 64'(cmd_err), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_spi_start", 64'(spi_start), 64'd0);
        check("rst_spi_dir", 64'(spi_dir), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_spi_data_tx", 64'(spi_data_tx), 64'd0);
        check("rst_spi_data_depth", 64'(spi_data_depth), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        idle_cycles(6);

        // single write: start in the cycle after the edge following acceptance
        base = n_rsp;
        send(1'b0, 8'd24, 24'hA5C3F0);
        check("write_start_early", 64'(spi_start), 64'd0);
        idle_cycles(1);
        check("write_start", 64'(spi_start), 64'd1);
        check("write_tx", 64'(spi_data_tx), 64'hA5C3F0);
        check("write_len", 64'(spi_data_depth), 64'd24);
        wait_idle(100);
        check("write_no_rsp", 64'(n_rsp), 64'(base));

        // single read
        base = n_rsp;
        rx_word = 24'h00123F;
        send(1'b1, 8'd24, 24'h800000);
        wait_idle(100);
        check("read_rsp_count", 64'(n_rsp), 64'(base + 1));
        check("read_rsp_data", 64'(rsp_data), 64'h00123F);

        // fill to full with the master stalled
        stall = 1'b1;
        idle_cycles(2);
        base = n_starts;
        for (int i = 0; i <= FD; i++) begin
            cmd_valid = 1'b1;
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_len   = 8'($urandom_range(1, DW));
            cmd_data  = DW'($urandom);
            @(negedge clk);
            ok = cmd_ready;
            check("fill_cmd_ready", 64'(ok), 64'(i < FD));
            if (ok) exp_q.push_back({cmd_dir, cmd_len, cmd_data});
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("full_level", 64'(level), 64'(FD));
        check("full_cmd_ready", 64'(cmd_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        check("full_no_start", 64'(n_starts), 64'(base));
        stall = 1'b0;
        @(posedge clk);
        #1;
        wait_idle(400);
        check("full_drain_starts", 64'(n_starts), 64'(base + FD));

        // simultaneous push and pop at level 3
        stall = 1'b1;
        idle_cycles(2);
        for (int i = 0; i < 3; i++) send_rand();
        @(negedge clk);
        check("pp_level_before", 64'(level), 64'd3);
        stall = 1'b0;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_len   = 8'd16;
        cmd_data  = DW'($urandom);
        @(negedge clk);
        check("pp_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_q.push_back({cmd_dir, cmd_len, cmd_data});
        check("pp_level_after", 64'(level), 64'd3);
        check("pp_start", 64'(spi_start), 64'd1);
        for (int i = 0; i < 20; i++) begin
            send_rand();
            idle_cycles($urandom_range(0, 3));
        end
        wait_idle(2000);

        // reset while a read is completing
        stall = 1'b1;
        idle_cycles(2);
        send(1'b1, 8'd16, DW'($urandom));
        send(1'b0, 8'd8, DW'($urandom));
        send(1'b1, 8'd24, DW'($urandom));
        @(negedge clk);
        stall = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while (!spi_read_finish && t < 100);
        check("mid_read_reached", 64'(spi_read_finish), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        exp_q.delete();
        rsp_q.delete();
        rsp_cyc_q.delete();
        @(negedge clk);
        check("mrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("mrst_level", 64'(level), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_spi_data_depth", 64'(spi_data_depth), 64'd0);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_starts;
        send(1'b0, 8'd12, DW'($urandom));
        wait_idle(200);
        check("after_reset_start", 64'(n_starts), 64'(base + 1));

        // length screening
        base = n_starts;
        send(1'b0, 8'd0, DW'($urandom));
        @(negedge clk);
        check("len0_level", 64'(level), 64'(len_bad(8'd0) ? 0 : 1));
        @(posedge clk);
        #1;
        send(1'b0, 8'd25, DW'($urandom));
        wait_idle(200);
        check("len_starts", 64'(n_starts), 64'(base + (len_bad(8'd25) ? 0 : 2)));

        // randomized mix including out-of-range lengths
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(25, 40));
            else l = 8'($urandom_range(1, DW));
            send(1'($urandom_range(0, 1)), l, DW'($urandom));
            idle_cycles($urandom_range(0, 6));
        end
        wait_idle(3000);
        idle_cycles(4);
        check("rsp_outstanding", 64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_queue.md
# spi_cmd_queue

Command queue and sequencer that sits directly upstream of the SPI master. Buffers host write/read requests in a FIFO, issues each one to the master with a single-cycle `spi_start` pulse, and holds all command fields stable for the full transaction. Captures read data on completion and presents it on a response port. One command is in flight at a time.

## Interface
Parameters:
- `data_depth`, 24: width of the command data and read-data words; matches the master's `data_depth`.
- `fifo_depth`, 8: command FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  queue can accept; equals `!full && !rst`.
- `cmd_dir`  in  1  0 = write, 1 = read.
- `cmd_len`  in  8  frame length in bits; forwarded as `spi_data_depth`.
- `cmd_data`  in  `data_depth`  transmit word; for reads, carries the header bits.
- `cmd_err`  out  1  one-cycle pulse when a command is rejected (see Configuration).
- `rsp_valid`  out  1  one-cycle pulse when read data is available.
- `rsp_data`  out  `data_depth`  last captured read word; held until the next capture.
- `spi_start`  out  1  to master; one-cycle start pulse.
- `spi_dir`  out  1  to master.
- `spi_data_depth`  out  8  to master; held for the whole transaction.
- `spi_data_tx`  out  `data_depth`  to master.
- `spi_ready`  in  1  from master; high when idle.
- `spi_read_finish`  in  1  from master; high for one SPI bit period at the end of a read.
- `spi_data_rx`  in  `data_depth`  from master.
- `level`  out  `$clog2(fifo_depth)+1`  FIFO occupancy.
- `busy`  out  1  high when the FIFO is non-empty or the state is not IDLE.

## Operation
- **Enqueue:** on `cmd_valid && cmd_ready`, write `{cmd_dir, cmd_len, cmd_data}` into the FIFO. There is no bypass path; a new entry becomes visible the cycle after the write.
- **States:**
  - IDLE: if the FIFO is non-empty and `spi_ready`, pop the head, register its fields onto `spi_dir`, `spi_data_depth` and `spi_data_tx`, pulse `spi_start`, and go to WAIT_BUSY.
  - WAIT_BUSY: on `spi_ready == 0`, go to WAIT_DONE.
  - WAIT_DONE: on `spi_ready == 1`, go to IDLE.
- **Field stability:** `spi_dir`, `spi_data_depth` and `spi_data_tx` change only on the cycle `spi_start` is asserted. The master uses `spi_data_depth` combinationally throughout the frame, so it must stay constant.
- **Read capture:** keep a registered copy of `spi_read_finish`. On its rising edge, in WAIT_DONE with `spi_dir == 1`: `rsp_data <= spi_data_rx`, and `rsp_valid` pulses the following cycle. Write transactions never raise `rsp_valid`.
- **Simultaneous push and pop:** both are allowed in one cycle; `level` is unchanged.
- **Full FIFO:** `cmd_ready` is low, and a push in that cycle is ignored.
- **Empty FIFO in IDLE:** no start is issued; outputs hold their last values.
- **Pointers:** wrap modulo `fifo_depth`; full/empty are derived from an extra pointer MSB.
- **Reset:** clears the pointers and returns to IDLE, aborting any mid-transaction state without a response. The master shares the reset source, inverted at top level. IDLE requires `spi_ready` before issuing, so a master that is still busy is never double-started.

## Timing
- Reset values:
  - `cmd_ready` 0 during reset, 1 on the first cycle after.
  - `cmd_err`, `rsp_valid`, `spi_start`, `spi_dir`: 0.
  - `rsp_data`, `spi_data_tx`: 0.
  - `spi_data_depth`: 0.
  - `level`: 0.
  - `busy`: 0.
- Latency, with an empty queue and an idle master: a command accepted at edge N produces `spi_start` high in the cycle after edge N+1.
- `spi_start` is exactly one cycle wide. It is never asserted outside IDLE or while `spi_ready == 0`.
- Back-to-back commands: the next `spi_start` comes no earlier than 1 cycle after the master's `spi_ready` returns high.
- `rsp_valid` arrives 2 cycles after the rising edge of `spi_read_finish`.

## Configuration
- `SPI_CMD_LEN_CHECK_EN` defined:
  - At enqueue, a command with `cmd_len == 0` or `cmd_len > data_depth` is accepted (handshake completes) but not stored.
  - `cmd_err` pulses the next cycle.
- `SPI_CMD_LEN_CHECK_EN` undefined:
  - All commands are stored and forwarded unchanged.
  - `cmd_err` is tied to 0.

## Test plan
- **Single write:** `cmd_dir=0`, `len=24`, `data=0xA5C3F0`, master idle → `spi_start` 2 cycles after accept; `spi_data_tx=0xA5C3F0` and `spi_data_depth=24` held until `spi_ready` rises; no `rsp_valid`.
- **Single read:** `dir=1`, `len=24`, master model returns `0x00123F` → `rsp_valid` one pulse; `rsp_data=0x00123F`; `busy` falls after `spi_ready` returns.
- **Fill to full:** push 9 commands with the master stalled (`spi_ready=0`) → 8 accepted, `cmd_ready=0` on the 9th, `level=8`. Release the master → 8 starts issued in FIFO order with `spi_start` pulses exactly 1 cycle wide.
- **Simultaneous push/pop:** at `level=3`, push while IDLE pops → `level` stays 3; entry order is preserved across pointer wrap after 20 commands.
- **Reset mid-read:** assert `rst` during WAIT_DONE → `level=0`, no `rsp_valid`; the next command starts only after `spi_ready=1`.
- **Length check (`SPI_CMD_LEN_CHECK_EN`):** `len=0`, then `len=25` → two `cmd_err` pulses, `level` stays 0, no `spi_start`. Without the macro, the same commands are issued with `spi_data_depth` 0 and 25.
